// File: rtl/fractal_pkg.sv
// Shared constants and the Q4.23 coordinate type for the fractal pixel front end.
package fractal_pkg;
  localparam int H_RES      = 640;
  localparam int V_RES      = 480;
  localparam int COORD_W    = 27;
  localparam int COORD_FRAC = 23;

  typedef logic signed [COORD_W-1:0] coord_t;

  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction
endpackage

// File: rtl/pixel_axis_counter.sv
// One scan axis: an index counter paired with an incrementally stepped coordinate.
module pixel_axis_counter
  import fractal_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  coord_t           i_clr_val,
  input  coord_t           i_step,
  input  logic [CNT_W-1:0] i_term_cnt,
  input  logic             i_adv,
  output logic             o_wrap,
  output logic [CNT_W-1:0] o_cnt,
  output coord_t           o_coord
);

  logic [CNT_W-1:0] r_cnt;
  coord_t           r_coord;
  logic             w_at_term;

  assign w_at_term = (r_cnt == i_term_cnt);
  assign o_wrap    = i_adv & w_at_term;
  assign o_cnt     = r_cnt;
  assign o_coord   = r_coord;

  // Coordinate reloads on wrap instead of stepping, so it never accumulates drift.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_coord <= i_clr_val;
    end else if (i_adv) begin
      if (w_at_term) begin
        r_cnt   <= '0;
        r_coord <= i_clr_val;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
        r_coord <= r_coord + i_step;
      end
    end
  end

endmodule

// File: rtl/pixel_iter_core.sv
// Raster scanner emitting pixel position and complex-plane coordinate per enabled clock.
// Optional end-of-frame flag output enabled by defining PIXEL_ITER_EOF_EN.
module pixel_iter_core
  import fractal_pkg::*;
#(
  parameter int STEP_SHIFT = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] x,
  output logic [8:0] y,
  output coord_t     c_re,
  output coord_t     c_im
`ifdef PIXEL_ITER_EOF_EN
  ,
  output logic       eof
`endif
);

  localparam int     STEP_I = 1 << (COORD_FRAC - STEP_SHIFT);
  localparam int     RE0_I  = -(1 << (COORD_FRAC - 1)) - (H_RES / 2) * STEP_I;
  localparam int     IM0_I  = (V_RES / 2) * STEP_I;
  localparam coord_t STEP_P = to_coord(STEP_I);
  localparam coord_t STEP_N = to_coord(-STEP_I);
  localparam coord_t RE0    = to_coord(RE0_I);
  localparam coord_t IM0    = to_coord(IM0_I);
  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  logic w_x_wrap;

  pixel_axis_counter #(.CNT_W(10)) u_x_axis (
    .clock      (clock),
    .reset      (reset),
    .i_clr_val  (RE0),
    .i_step     (STEP_P),
    .i_term_cnt (X_LAST),
    .i_adv      (en),
    .o_wrap     (w_x_wrap),
    .o_cnt      (x),
    .o_coord    (c_re)
  );

`ifdef PIXEL_ITER_EOF_EN
  logic w_frame_wrap;
  logic r_eof;
`else
  logic w_frame_wrap_unused;
`endif

  // Imaginary axis runs downward, hence the negative step.
  pixel_axis_counter #(.CNT_W(9)) u_y_axis (
    .clock      (clock),
    .reset      (reset),
    .i_clr_val  (IM0),
    .i_step     (STEP_N),
    .i_term_cnt (Y_LAST),
    .i_adv      (w_x_wrap),
`ifdef PIXEL_ITER_EOF_EN
    .o_wrap     (w_frame_wrap),
`else
    .o_wrap     (w_frame_wrap_unused),
`endif
    .o_cnt      (y),
    .o_coord    (c_im)
  );

`ifdef PIXEL_ITER_EOF_EN
  // Set on the step into the last pixel, cleared on the step out of it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_eof <= 1'b0;
    end else if (w_frame_wrap) begin
      r_eof <= 1'b0;
    end else if (en && (x == X_LAST - 10'd1) && (y == Y_LAST)) begin
      r_eof <= 1'b1;
    end
  end

  assign eof = r_eof;
`endif

endmodule

// File: tb/tb_pixel_iter_core.sv
// Self-checking bench for pixel_iter_core against a pixel-index reference model.
module tb_pixel_iter_core;

  localparam int W_PIX = 640;
  localparam int H_PIX = 480;
  localparam int FRAME = W_PIX * H_PIX;
  localparam int STEP  = 65536;
  localparam int RE0   = -25165824;
  localparam int IM0   = 15728640;

  logic               clock = 1'b0;
  logic               reset;
  logic               en;
  logic [9:0]         x;
  logic [8:0]         y;
  logic signed [26:0] c_re;
  logic signed [26:0] c_im;
`ifdef PIXEL_ITER_EOF_EN
  logic               eof;
`endif

  int checks   = 0;
  int failures = 0;
  int p        = 0;

  always #5 clock = ~clock;

  pixel_iter_core #(.STEP_SHIFT(7)) dut (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .x     (x),
    .y     (y),
    .c_re  (c_re),
    .c_im  (c_im)
`ifdef PIXEL_ITER_EOF_EN
    ,
    .eof   (eof)
`endif
  );

  function automatic logic [9:0] mx(input int idx);
    return 10'(idx % W_PIX);
  endfunction
  function automatic logic [8:0] my(input int idx);
    return 9'(idx / W_PIX);
  endfunction
  function automatic logic signed [26:0] mre(input int idx);
    return 27'(RE0 + (idx % W_PIX) * STEP);
  endfunction
  function automatic logic signed [26:0] mim(input int idx);
    return 27'(IM0 - (idx / W_PIX) * STEP);
  endfunction

  task automatic tick(input logic e);
    en = e;
    @(posedge clock);
    #1;
    if (e) p = (p + 1) % FRAME;
  endtask

  task automatic apply_reset();
    en    = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    p     = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({x, y, c_re, c_im} !== {10'd0, 9'd0, 27'(RE0), 27'(IM0)}) begin
      failures++;
      $display("FAIL reset_state: got x=%0d y=%0d re=%0d im=%0d want 0 0 %0d %0d",
               x, y, c_re, c_im, RE0, IM0);
    end
`ifdef PIXEL_ITER_EOF_EN
    checks++;
    if (eof !== 1'b0) begin
      failures++;
      $display("FAIL reset_eof: got %b want 0", eof);
    end
`endif
  endtask

  task automatic test_first_pixel();
    apply_reset();
    tick(1'b1);
    checks++;
    if ({x, y, c_re, c_im} !== {10'd1, 9'd0, 27'sd25100288 * -27'sd1, 27'sd15728640}) begin
      failures++;
      $display("FAIL first_pixel: got x=%0d y=%0d re=%0d im=%0d want 1 0 -25100288 15728640",
               x, y, c_re, c_im);
    end
  endtask

  task automatic test_line_wrap();
    apply_reset();
    for (int i = 0; i < 640; i++) tick(1'b1);
    checks++;
    if ({x, y, c_re, c_im} !== {10'd0, 9'd1, -27'sd25165824, 27'sd15663104}) begin
      failures++;
      $display("FAIL line_wrap: got x=%0d y=%0d re=%0d im=%0d want 0 1 -25165824 15663104",
               x, y, c_re, c_im);
    end
  endtask

  task automatic test_hold();
    int pause;
    apply_reset();
    for (int i = 0; i < 8000; i++) tick(1'b1);
    checks++;
    if ({x, y, c_re} !== {10'd320, 9'd12, -27'sd4194304}) begin
      failures++;
      $display("FAIL hold_before: got x=%0d y=%0d re=%0d want 320 12 -4194304", x, y, c_re);
    end
    pause = $urandom_range(40, 20);
    for (int i = 0; i < pause; i++) tick(1'b0);
    checks++;
    if ({x, y, c_re, c_im} !== {10'd320, 9'd12, -27'sd4194304, 27'(IM0 - 12 * STEP)}) begin
      failures++;
      $display("FAIL hold_after: got x=%0d y=%0d re=%0d im=%0d want 320 12 -4194304 %0d",
               x, y, c_re, c_im, IM0 - 12 * STEP);
    end
    for (int i = 0; i < 400; i++) begin
      tick(logic'($urandom_range(1, 0)));
      checks++;
      if ({x, y, c_re, c_im} !== {mx(p), my(p), mre(p), mim(p)}) begin
        failures++;
        if (failures < 20)
          $display("FAIL random_en: pix %0d got x=%0d y=%0d re=%0d im=%0d want %0d %0d %0d %0d",
                   p, x, y, c_re, c_im, mx(p), my(p), mre(p), mim(p));
      end
    end
  endtask

  task automatic test_full_frame();
    int cyc;
    apply_reset();
    cyc = 0;
    while (p != FRAME - 1 && cyc < 400000) begin
      tick(($urandom_range(7, 0) != 0) ? 1'b1 : 1'b0);
      cyc++;
      checks++;
      if ({x, y, c_re, c_im} !== {mx(p), my(p), mre(p), mim(p)}) begin
        failures++;
        if (failures < 20)
          $display("FAIL frame_scan: pix %0d got x=%0d y=%0d re=%0d im=%0d want %0d %0d %0d %0d",
                   p, x, y, c_re, c_im, mx(p), my(p), mre(p), mim(p));
      end
`ifdef PIXEL_ITER_EOF_EN
      checks++;
      if (eof !== (p == FRAME - 1)) begin
        failures++;
        if (failures < 20) $display("FAIL frame_eof: pix %0d got %b want %b", p, eof, (p == FRAME - 1));
      end
`endif
    end
    checks++;
    if (p != FRAME - 1) begin
      failures++;
      $display("FAIL frame_budget: reached pix %0d want %0d", p, FRAME - 1);
    end
    checks++;
    if ({x, y, c_re, c_im} !== {10'd639, 9'd479, 27'sd16711680, -27'sd15663104}) begin
      failures++;
      $display("FAIL last_pixel: got x=%0d y=%0d re=%0d im=%0d want 639 479 16711680 -15663104",
               x, y, c_re, c_im);
    end
  endtask

  task automatic test_frame_wrap();
    tick(1'b1);
    checks++;
    if ({x, y, c_re, c_im} !== {10'd0, 9'd0, 27'(RE0), 27'(IM0)}) begin
      failures++;
      $display("FAIL frame_wrap: got x=%0d y=%0d re=%0d im=%0d want 0 0 %0d %0d",
               x, y, c_re, c_im, RE0, IM0);
    end
`ifdef PIXEL_ITER_EOF_EN
    checks++;
    if (eof !== 1'b0) begin
      failures++;
      $display("FAIL wrap_eof: got %b want 0", eof);
    end
`endif
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0);
      checks++;
      if ({x, y, c_re, c_im} !== {mx(p), my(p), mre(p), mim(p)}) begin
        failures++;
        if (failures < 20)
          $display("FAIL second_frame: pix %0d got x=%0d y=%0d re=%0d im=%0d want %0d %0d %0d %0d",
                   p, x, y, c_re, c_im, mx(p), my(p), mre(p), mim(p));
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = $urandom_range(2000, 700);
    for (int i = 0; i < n; i++) tick(1'b1);
    @(negedge clock);
    #2;
    en    = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if ({x, y, c_re, c_im} !== {10'd0, 9'd0, 27'(RE0), 27'(IM0)}) begin
      failures++;
      $display("FAIL async_reset: got x=%0d y=%0d re=%0d im=%0d want 0 0 %0d %0d",
               x, y, c_re, c_im, RE0, IM0);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({x, y} !== {10'd0, 9'd0}) begin
      failures++;
      $display("FAIL reset_held: got x=%0d y=%0d want 0 0", x, y);
    end
    @(negedge clock);
    reset = 1'b0;
    p     = 0;
    tick(1'b1);
    checks++;
    if ({x, y, c_re, c_im} !== {mx(p), my(p), mre(p), mim(p)}) begin
      failures++;
      $display("FAIL after_release: got x=%0d y=%0d re=%0d im=%0d want %0d %0d %0d %0d",
               x, y, c_re, c_im, mx(p), my(p), mre(p), mim(p));
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    test_reset();
    test_first_pixel();
    test_line_wrap();
    test_hold();
    test_full_frame();
    test_frame_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
